// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue controller: op codes, instruction
// field positions and the controller FSM states.
// Optional feature macro: ILLEGAL_TRAP_EN (adds the terminal HALT state).
package alu_issue_pkg;

  localparam int unsigned OP_W   = 3;
  localparam int unsigned REG_AW = 3;

  // ALU function codes; the alu decodes the same values on EXE_CMD
  localparam logic [OP_W-1:0] OP_NOP = 3'b000;
  localparam logic [OP_W-1:0] OP_ADD = 3'b001;
  localparam logic [OP_W-1:0] OP_SUB = 3'b010;
  localparam logic [OP_W-1:0] OP_SLL = 3'b011;
  localparam logic [OP_W-1:0] OP_SRL = 3'b100;

  // Instruction word field positions
  localparam int unsigned OP_MSB   = 15;
  localparam int unsigned OP_LSB   = 13;
  localparam int unsigned IMM_BIT  = 12;
  localparam int unsigned RD_MSB   = 11;
  localparam int unsigned RD_LSB   = 9;
  localparam int unsigned RS_MSB   = 8;
  localparam int unsigned RS_LSB   = 6;
  localparam int unsigned RT_MSB   = 5;
  localparam int unsigned RT_LSB   = 3;
  localparam int unsigned IMM8_MSB = 7;
  localparam int unsigned IMM8_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_WB
`ifdef ILLEGAL_TRAP_EN
    , ST_HALT
`endif
  } state_t;

  // Codes above SRL have no ALU function
  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return op <= OP_SRL;
  endfunction

endpackage

// File: rtl/issue_regfile.sv
// REGS x N register file: async clear, one write port, three combinational
// read ports. r0 always reads as zero and is never written.
module issue_regfile
  import alu_issue_pkg::*;
#(
  parameter int unsigned N    = 8,
  parameter int unsigned REGS = 8,
  localparam int unsigned AW  = $clog2(REGS)
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [N-1:0]  rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [N-1:0]  rdata_b,
  input  logic [AW-1:0] raddr_d,
  output logic [N-1:0]  rdata_d
);

  logic [N-1:0] mem [REGS];

  // Storage: cleared on reset, single write port skipping r0
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < int'(REGS); i++) mem[i] <= '0;
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : mem[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : mem[raddr_b];
  assign rdata_d = (raddr_d == '0) ? '0 : mem[raddr_d];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Command-issuing side of the ALU interface: accepts instruction words,
// reads operands, drives the external alu and writes its result back.
// Optional feature macro: ILLEGAL_TRAP_EN (illegal op -> sticky flag + HALT).
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int unsigned N    = 8,
  parameter int unsigned REGS = 8
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  output logic              instr_ready,
  output logic [OP_W-1:0]   exe_cmd,
  output logic [N-1:0]      alu_a,
  output logic [N-1:0]      alu_b,
  input  logic [N-1:0]      alu_result,
  output logic              done,
  output logic [REG_AW-1:0] wb_addr,
  output logic [N-1:0]      wb_data,
  output logic              illegal_op,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [N-1:0]      dbg_data
);

  state_t state_q, state_d;
  logic [15:0]       instr_q, instr_d;
  logic [OP_W-1:0]   exe_cmd_d;
  logic [N-1:0]      alu_a_d, alu_b_d, wb_data_d;
  logic [REG_AW-1:0] wb_addr_d;
  logic              done_d, ready_d, rf_we;
  logic [N-1:0]      rdata_a, rdata_b;

  logic [OP_W-1:0]   op, eff_op;
  logic              imm;
  logic [REG_AW-1:0] rd, rs, rt;
  logic [7:0]        imm8;

  assign op   = instr_q[OP_MSB:OP_LSB];
  assign imm  = instr_q[IMM_BIT];
  assign rd   = instr_q[RD_MSB:RD_LSB];
  assign rs   = instr_q[RS_MSB:RS_LSB];
  assign rt   = instr_q[RT_MSB:RT_LSB];
  assign imm8 = instr_q[IMM8_MSB:IMM8_LSB];

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
  assign eff_op     = op;
  assign illegal_op = illegal_q;
`else
  assign eff_op     = op_legal(op) ? op : OP_NOP;
  assign illegal_op = 1'b0;
`endif

  issue_regfile #(.N(N), .REGS(REGS)) u_rf (
    .clk     (clk),
    .n_reset (n_reset),
    .we      (rf_we),
    .waddr   (rd),
    .wdata   (wb_data),
    .raddr_a (imm ? rd : rs),
    .rdata_a (rdata_a),
    .raddr_b (rt),
    .rdata_b (rdata_b),
    .raddr_d (dbg_addr),
    .rdata_d (dbg_data)
  );

  // State and registered outputs
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= ST_IDLE;
      instr_q     <= '0;
      exe_cmd     <= OP_NOP;
      alu_a       <= '0;
      alu_b       <= '0;
      wb_addr     <= '0;
      wb_data     <= '0;
      done        <= 1'b0;
      instr_ready <= 1'b1;
`ifdef ILLEGAL_TRAP_EN
      illegal_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      exe_cmd     <= exe_cmd_d;
      alu_a       <= alu_a_d;
      alu_b       <= alu_b_d;
      wb_addr     <= wb_addr_d;
      wb_data     <= wb_data_d;
      done        <= done_d;
      instr_ready <= ready_d;
`ifdef ILLEGAL_TRAP_EN
      illegal_q   <= illegal_d;
`endif
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    exe_cmd_d = exe_cmd;
    alu_a_d   = alu_a;
    alu_b_d   = alu_b;
    wb_addr_d = wb_addr;
    wb_data_d = wb_data;
    done_d    = 1'b0;
    rf_we     = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    case (state_q)
      ST_IDLE: begin
        exe_cmd_d = OP_NOP;
        if (instr_valid) begin
          instr_d = instr;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        alu_a_d   = rdata_a;
        alu_b_d   = imm ? N'(imm8) : rdata_b;
        exe_cmd_d = eff_op;
        state_d   = ST_EXEC;
`ifdef ILLEGAL_TRAP_EN
        if (!op_legal(op)) begin
          illegal_d = 1'b1;
          exe_cmd_d = OP_NOP;
          state_d   = ST_HALT;
        end
`endif
      end
      ST_EXEC: begin
        wb_addr_d = rd;
        wb_data_d = (eff_op == OP_NOP) ? '0 : alu_result;
        done_d    = 1'b1;
        state_d   = ST_WB;
      end
      ST_WB: begin
        rf_we     = (rd != '0) && (eff_op != OP_NOP);
        exe_cmd_d = OP_NOP;
        state_d   = ST_IDLE;
      end
`ifdef ILLEGAL_TRAP_EN
      ST_HALT: state_d = ST_HALT;
`endif
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural model of the alu.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_ready;
  logic [2:0]  exe_cmd;
  logic [7:0]  alu_a, alu_b, alu_result;
  logic        done;
  logic [2:0]  wb_addr;
  logic [7:0]  wb_data;
  logic        illegal_op;
  logic [2:0]  dbg_addr = '0;
  logic [7:0]  dbg_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .exe_cmd     (exe_cmd),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result),
    .done        (done),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .illegal_op  (illegal_op),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  // External alu model: saturating add, wrapping sub, logical shifts
  logic [8:0] sum;
  always_comb begin
    sum = {1'b0, alu_a} + {1'b0, alu_b};
    case (exe_cmd)
      3'b001:  alu_result = sum[8] ? 8'hFF : sum[7:0];
      3'b010:  alu_result = alu_a - alu_b;
      3'b011:  alu_result = alu_a << alu_b;
      3'b100:  alu_result = alu_a >> alu_b;
      default: alu_result = 8'h00;
    endcase
  end

  function automatic logic [15:0] enc_i(input logic [2:0] op, input logic [2:0] rd,
                                        input logic [7:0] imm8);
    return {op, 1'b1, rd, 1'b0, imm8};
  endfunction

  function automatic logic [15:0] enc_r(input logic [2:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [2:0] rt);
    return {op, 1'b0, rd, rs, rt, 3'b000};
  endfunction

  // Reads one register through the debug port
  task automatic dbg_read(input logic [2:0] a, output logic [7:0] d);
    dbg_addr = a;
    #1;
    d = dbg_data;
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_reset = 1'b0;
    @(negedge clk);
    n_reset = 1'b1;
  endtask

  // Issues one word; lat = cycle index of done after accept (0 = no done pulse),
  // ea/eb/ec = operands and command seen in the EXEC cycle. Returns after WB.
  task automatic issue(input logic [15:0] w, output int lat,
                       output logic [7:0] ea, output logic [7:0] eb, output logic [2:0] ec);
    int n;
    @(negedge clk);
    instr = w;
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 instr_valid = 1'b0;
    lat = 0;
    ea = 'x; eb = 'x; ec = 'x;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin ea = alu_a; eb = alu_b; ec = exe_cmd; end
      if (done) begin lat = c + 1; break; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    n_reset = 1'b0;
    #12;
    checks++;
    if ({exe_cmd, alu_a, alu_b, wb_addr, wb_data, done, illegal_op} !== 31'd0) begin
      errors++;
      $display("FAIL reset_outputs: got cmd=%h a=%h b=%h wa=%h wd=%h done=%b ill=%b required all 0",
               exe_cmd, alu_a, alu_b, wb_addr, wb_data, done, illegal_op);
    end
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b required 1", instr_ready);
    end
    dbg_read(3'd7, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL reset_rf: got %h required 00", d); end
    @(negedge clk);
    n_reset = 1'b1;
  endtask

  task automatic test_add_chain();
    int lat; logic [7:0] ea, eb, d; logic [2:0] ec;
    issue(enc_i(3'b001, 3'd1, 8'h05), lat, ea, eb, ec);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL addi1_latency: got %0d required 3", lat); end
    issue(enc_i(3'b001, 3'd2, 8'h03), lat, ea, eb, ec);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL addi2_latency: got %0d required 3", lat); end
    issue(enc_r(3'b001, 3'd3, 3'd1, 3'd2), lat, ea, eb, ec);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL add_latency: got %0d required 3", lat); end
    checks++;
    if ({ea, eb, ec} !== {8'h05, 8'h03, 3'b001}) begin
      errors++; $display("FAIL add_operands: got a=%h b=%h cmd=%h required 05 03 1", ea, eb, ec);
    end
    checks++;
    if (wb_addr !== 3'd3 || wb_data !== 8'h08) begin
      errors++; $display("FAIL add_wb: got addr=%0d data=%h required 3 08", wb_addr, wb_data);
    end
    checks++;
    if (exe_cmd !== 3'b000 || instr_ready !== 1'b1) begin
      errors++; $display("FAIL idle_after_wb: got cmd=%h ready=%b required 0 1", exe_cmd, instr_ready);
    end
    dbg_read(3'd3, d);
    checks++;
    if (d !== 8'h08) begin errors++; $display("FAIL add_r3: got %h required 08", d); end
  endtask

  task automatic test_saturate();
    int lat; logic [7:0] ea, eb, d; logic [2:0] ec;
    do_reset();
    issue(enc_i(3'b001, 3'd1, 8'hF0), lat, ea, eb, ec);
    issue(enc_i(3'b001, 3'd1, 8'h20), lat, ea, eb, ec);
    checks++;
    if ({ea, eb, ec} !== {8'hF0, 8'h20, 3'b001}) begin
      errors++; $display("FAIL sat_operands: got a=%h b=%h cmd=%h required F0 20 1", ea, eb, ec);
    end
    dbg_read(3'd1, d);
    checks++;
    if (d !== 8'hFF) begin errors++; $display("FAIL sat_r1: got %h required FF", d); end
  endtask

  task automatic test_sub_shift();
    int lat; logic [7:0] ea, eb, d; logic [2:0] ec;
    do_reset();
    issue(enc_i(3'b001, 3'd1, 8'h03), lat, ea, eb, ec);
    issue(enc_i(3'b010, 3'd1, 8'h05), lat, ea, eb, ec);
    dbg_read(3'd1, d);
    checks++;
    if (d !== 8'hFE) begin errors++; $display("FAIL subi_r1: got %h required FE", d); end
    issue(enc_i(3'b011, 3'd1, 8'h02), lat, ea, eb, ec);
    dbg_read(3'd1, d);
    checks++;
    if (d !== 8'hF8) begin errors++; $display("FAIL slli_r1: got %h required F8", d); end
    issue(enc_i(3'b100, 3'd1, 8'h03), lat, ea, eb, ec);
    dbg_read(3'd1, d);
    checks++;
    if (d !== 8'h1F) begin errors++; $display("FAIL srli_r1: got %h required 1F", d); end
  endtask

  task automatic test_back_to_back();
    logic [7:1] exp_rdy;
    logic [7:1] exp_done;
    logic [7:0] d;
    exp_rdy  = 7'b1000100;
    exp_done = 7'b0100010;
    @(negedge clk);
    instr = enc_i(3'b001, 3'd0, 8'h55);
    instr_valid = 1'b1;
    checks++;
    if (instr_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0: got %b required 1", instr_ready); end
    @(posedge clk);
    #1;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk);
      #1;
      checks++;
      if (instr_ready !== exp_rdy[e] || done !== exp_done[e]) begin
        errors++;
        $display("FAIL b2b_cycle%0d: got ready=%b done=%b required ready=%b done=%b",
                 e, instr_ready, done, exp_rdy[e], exp_done[e]);
      end
      if (exp_done[e]) begin
        checks++;
        if (wb_data !== 8'h55 || wb_addr !== 3'd0) begin
          errors++; $display("FAIL b2b_wb%0d: got addr=%0d data=%h required 0 55", e, wb_addr, wb_data);
        end
      end
      if (e == 6) instr_valid = 1'b0;
    end
    dbg_read(3'd0, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL b2b_r0: got %h required 00", d); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [7:0] ea, eb, d; logic [2:0] ec;
    logic saw_done;
    do_reset();
    issue(enc_i(3'b001, 3'd4, 8'h07), lat, ea, eb, ec);
    dbg_read(3'd4, d);
    checks++;
    if (d !== 8'h07) begin errors++; $display("FAIL mid_pre_r4: got %h required 07", d); end
    @(negedge clk);
    instr = enc_i(3'b001, 3'd4, 8'h11);
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (alu_a !== 8'h07 || alu_b !== 8'h11 || exe_cmd !== 3'b001) begin
      errors++; $display("FAIL mid_exec: got a=%h b=%h cmd=%h required 07 11 1", alu_a, alu_b, exe_cmd);
    end
    #1 n_reset = 1'b0;
    #1;
    checks++;
    if ({exe_cmd, alu_a, alu_b, wb_addr, wb_data, done} !== 30'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got cmd=%h a=%h b=%h wa=%h wd=%h done=%b required all 0",
               exe_cmd, alu_a, alu_b, wb_addr, wb_data, done);
    end
    dbg_read(3'd4, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL mid_reset_r4: got %h required 00", d); end
    @(negedge clk);
    n_reset = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0 || instr_ready !== 1'b1) begin
      errors++; $display("FAIL mid_after_release: got done_seen=%b ready=%b required 0 1", saw_done, instr_ready);
    end
    dbg_read(3'd4, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL mid_after_r4: got %h required 00", d); end
  endtask

  task automatic test_illegal();
    int lat; logic [7:0] ea, eb, d; logic [2:0] ec;
    logic [15:0] w;
    do_reset();
    issue(enc_i(3'b001, 3'd5, 8'h09), lat, ea, eb, ec);
    w = enc_i(3'b110, 3'd5, 8'h22);
`ifdef ILLEGAL_TRAP_EN
    begin
      logic saw_done;
      @(negedge clk);
      instr = w;
      instr_valid = 1'b1;
      @(posedge clk);
      #1 instr_valid = 1'b0;
      saw_done = 1'b0;
      for (int i = 0; i < 8; i++) begin
        @(posedge clk);
        #1;
        if (done) saw_done = 1'b1;
      end
      checks++;
      if (illegal_op !== 1'b1 || instr_ready !== 1'b0 || saw_done !== 1'b0) begin
        errors++; $display("FAIL trap_halt: got ill=%b ready=%b done_seen=%b required 1 0 0",
                           illegal_op, instr_ready, saw_done);
      end
      dbg_read(3'd5, d);
      checks++;
      if (d !== 8'h09) begin errors++; $display("FAIL trap_r5: got %h required 09", d); end
      do_reset();
      #1;
      checks++;
      if (illegal_op !== 1'b0 || instr_ready !== 1'b1) begin
        errors++; $display("FAIL trap_cleared: got ill=%b ready=%b required 0 1", illegal_op, instr_ready);
      end
    end
`else
    issue(w, lat, ea, eb, ec);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL illegal_latency: got %0d required 3", lat); end
    checks++;
    if (ec !== 3'b000 || wb_data !== 8'h00 || illegal_op !== 1'b0) begin
      errors++; $display("FAIL illegal_nop: got cmd=%h wd=%h ill=%b required 0 00 0", ec, wb_data, illegal_op);
    end
    dbg_read(3'd5, d);
    checks++;
    if (d !== 8'h09) begin errors++; $display("FAIL illegal_r5: got %h required 09", d); end
`endif
  endtask

  initial begin
    test_reset();
    test_add_chain();
    test_saturate();
    test_sub_shift();
    test_back_to_back();
    test_reset_mid();
    test_illegal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Command-issuing end of the ALU interface.
- Accepts 16-bit instruction words over a valid/ready handshake and decodes them.
- Holds the 8x8 register file, drives EXE_CMD and operands a/b to the external alu, captures its combinational result and writes it back.
- Forms the control/datapath core of the single-stage 8-bit processor; the alu stays a separate instance.

Parameters:
- N, 8: data width; must match the alu's n.
- REGS, 8: register-file depth; address width 3. r0 reads as 0 and writes to it are discarded.

Ports:
- clk  in  1  system clock, rising edge.
- n_reset  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction word present.
- instr  in  16  instruction word.
- instr_ready  out  1  block can accept an instruction.
- exe_cmd  out  3  ALU function code to alu EXE_CMD.
- alu_a  out  N  ALU operand a.
- alu_b  out  N  ALU operand b.
- alu_result  in  N  ALU result (combinational from alu_a/alu_b/exe_cmd).
- done  out  1  one-cycle pulse on writeback.
- wb_addr  out  3  destination register of the last completed instruction.
- wb_data  out  N  value written by the last completed instruction.
- illegal_op  out  1  sticky illegal-opcode flag (see Optional Feature).
- dbg_addr  in  3  debug register-file read address.
- dbg_data  out  N  combinational read of rf[dbg_addr]; r0 returns 0.

Behaviour:
- Instruction fields:
  - [15:13] op.
  - [12] imm.
  - [11:9] rd.
  - [8:6] rs.
  - [5:3] rt.
  - [7:0] imm8 (valid only when imm=1).
- Operand selection:
  - imm=0: a=rf[rs], b=rf[rt].
  - imm=1: a=rf[rd], b=imm8.
- Op codes: 000 NOP, 001 ADD (saturates at 8'hFF inside the alu), 010 SUB (wraps mod 2^N), 011 SLL, 100 SRL. 101-111 are illegal.
- FSM states: IDLE, READ, EXEC, WB.
  - IDLE: instr_ready=1. On instr_valid, register instr and go to READ. No other input is sampled.
  - READ: register alu_a, alu_b and exe_cmd from the decoded fields; go to EXEC.
  - EXEC: exe_cmd/alu_a/alu_b stay stable; register alu_result into wb_data and rd into wb_addr; go to WB.
  - WB: write rf[rd]=wb_data unless rd==0 or op==NOP. Pulse done=1 for this cycle only; go to IDLE.
- Timing:
  - Handshake accepted at edge k; done is high in cycle k+3.
  - Throughput is one instruction per 4 cycles.
  - instr_ready is 0 in READ/EXEC/WB.
- NOP: passes through all states and pulses done, with wb_data=0 and no register write.
- exe_cmd returns to NOP (000) in IDLE. alu_a/alu_b hold their last values.
- Operands read in READ see the writeback of the previous instruction (WB precedes IDLE), so no hazard exists.
- Register file and dbg_data:
  - dbg_data is combinational and reflects a write from the clock edge that ends WB.
- Reset (async, any state, including mid-instruction):
  - State goes to IDLE and all rf entries clear to 0.
  - exe_cmd=000, alu_a=alu_b=0, wb_addr=0, wb_data=0, done=0, illegal_op=0.
  - The in-flight instruction is discarded with no write.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: an illegal op detected in READ sets illegal_op=1 (sticky until reset). The FSM enters a terminal HALT state, with instr_ready=0, no done and no write, until n_reset.
- Undefined: illegal ops decode as NOP, including the done pulse. illegal_op is tied 0 and there is no HALT state.

Decomposition:
- Package alu_issue_pkg holds:
  - op code localparams, shared with the alu's code definitions so both ends agree;
  - instruction field bit positions;
  - the FSM state enum.
- One sub-module, issue_regfile: REGS x N register file with async clear, one write port and three combinational read ports (rs/rd, rt, dbg), r0 forced to 0.

Test Plan:
- Reset, then ADDI r1,#8'h05 then ADDI r2,#8'h03 then ADD r3,r1,r2 -> done three times, each 3 cycles after accept; dbg r3 = 8'h08, wb_addr=3.
- r1=8'hF0, ADDI r1,#8'h20 -> alu_a=F0, alu_b=20, exe_cmd=001; r1 = 8'hFF (saturated).
- r1=8'h03, SUBI r1,#8'h05 -> r1=8'hFE; SLLI r1,#2 -> r1=8'hF8; SRLI r1,#3 -> r1=8'h1F.
- ADDI r0,#8'h55 -> done pulses, wb_data=8'h55, dbg r0 stays 0; instr_valid held high throughout -> a second accept occurs only in the IDLE cycle after done.
- Assert n_reset low during EXEC of ADDI r4,#8'h11 -> all outputs 0 immediately, r4=0, and no done follows reset release.
- op=3'b110: with ILLEGAL_TRAP_EN -> illegal_op=1 and instr_ready stuck 0 until reset. Without it -> done pulses, no write, illegal_op=0.
